// File: rtl/dff_pipe_scan.sv
// dff_pipe_scan: DEPTH-stage, WIDTH-bit register pipeline with per-stage
// valid bits, stall, synchronous flush, optional data gating and a scan
// chain running through every state flop.
//
// All state lives in one flat vector laid out in scan-chain order:
//   bit k*(WIDTH+1)              : valid[k]
//   bits k*(WIDTH+1)+1 +: WIDTH  : data[k] (LSB first)
// This makes the scan shift a single one-bit shift of the whole vector.
// The same layout also gives so = data[DEPTH-1][WIDTH-1] = the top bit.
module dff_pipe_scan #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit GATE_DATA = 1'b0
) (
    input  logic                         gclk,
    input  logic                         rnot,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         se,
    input  logic                         si,
    output logic                         so
);

    localparam int SW = WIDTH + 1;      // bits per stage (valid + data)
    localparam int L  = DEPTH * SW;     // scan chain length
    localparam int CW = $clog2(DEPTH+1);

    logic [L-1:0] chain_q;
    logic [L-1:0] chain_d;

    // Next-state selection with priority scan > flush > advance > hold.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        chain_d = chain_q;
        if (se) begin
            chain_d = {chain_q[L-2:0], si};
        end else if (flush) begin
            // Drop all valid bits; data holds so nothing toggles needlessly.
            for (int k = 0; k < DEPTH; k++) begin
                chain_d[k*SW] = 1'b0;
            end
        end else if (en) begin
            // Stage 0 takes the pipeline inputs.
            chain_d[0] = in_valid;
            if (!GATE_DATA || in_valid) begin
                chain_d[1 +: WIDTH] = d;
            end
            // Stage k takes stage k-1; in gating mode only valid words move.
            for (int k = 1; k < DEPTH; k++) begin
                chain_d[k*SW] = chain_q[(k-1)*SW];
                if (!GATE_DATA || chain_q[(k-1)*SW]) begin
                    chain_d[k*SW+1 +: WIDTH] = chain_q[(k-1)*SW+1 +: WIDTH];
                end
            end
        end
    end

    // State register; reset clears every valid and data bit immediately.
    always_ff @(posedge gclk or negedge rnot) begin
        // NOTE: the reset is asynchronous (in the sensitivity list) so the
        // outputs clear without a clock; sequential state uses <= only, so
        // every flop samples the pre-edge value of its neighbour.
        if (!rnot) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    // Population count of the valid bits, kept purely combinational so it
    // tracks scan loads and flushes without extra state.
    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(chain_q[k*SW]);
        end
    end

    // Outputs come straight from the last-stage flops.
    assign q         = chain_q[L-WIDTH +: WIDTH];
    assign out_valid = chain_q[L-SW];
    assign so        = chain_q[L-1];

endmodule
